// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter with saturate/wrap/reload/one-shot boundary modes and a terminal-count pulse.
// One-cycle step latency; qd/tc/done are registered, at_lo/at_hi decode qd directly; no backpressure.
module bounded_updown_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  d,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  qd,
    output logic              tc,
    output logic              at_lo,
    output logic              at_hi,
    output logic              done
);

    typedef enum logic {RUN, STOPPED} state_t;

    localparam logic [1:0] MODE_SAT    = 2'b00;
    localparam logic [1:0] MODE_WRAP   = 2'b01;
    localparam logic [1:0] MODE_RELOAD = 2'b10;

    state_t           state, state_n;
    logic [WIDTH-1:0] reload_val, reload_n, qd_n;
    logic             tc_n, done_n;

    logic [WIDTH:0]   qd_ext, step_ext, sum, diff, nxt;
    logic             up_evt, dn_evt, evt, do_step;

    // Extra carry/borrow bit keeps crossings past 0 or 2^WIDTH-1 visible.
    assign qd_ext   = {1'b0, qd};
    assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign sum      = qd_ext + step_ext;
    assign diff     = qd_ext - step_ext;
    assign up_evt   = sum > {1'b0, hi};
    assign dn_evt   = (qd_ext < step_ext) || (diff < {1'b0, lo});
    assign nxt      = up_down ? sum : diff;
    assign evt      = up_down ? up_evt : dn_evt;
    assign do_step  = en && (state == RUN) && (lo <= hi) && (step != '0);

    assign at_lo = (qd == lo);
    assign at_hi = (qd == hi);

    always_comb begin
        state_n  = state;
        qd_n     = qd;
        reload_n = reload_val;
        tc_n     = 1'b0;
        done_n   = done;
        if (load) begin
            qd_n     = d;
            reload_n = d;
            done_n   = 1'b0;
            state_n  = RUN;
        end else if (do_step) begin
            if (!evt) begin
                qd_n = nxt[WIDTH-1:0];
            end else begin
                tc_n = 1'b1;
                case (mode)
                    MODE_SAT:    qd_n = up_down ? hi : lo;
                    MODE_WRAP:   qd_n = up_down ? lo : hi;
                    MODE_RELOAD: qd_n = reload_val;
                    default: begin
                        qd_n    = up_down ? hi : lo;
                        done_n  = 1'b1;
                        state_n = STOPPED;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state      <= RUN;
            qd         <= '0;
            reload_val <= '0;
            tc         <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            qd         <= qd_n;
            reload_val <= reload_n;
            tc         <= tc_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_bounded_updown_counter.sv
// Directed bench for bounded_updown_counter: 8-bit instance for most cases, 16-bit instance for the top-of-range saturate.
module tb_bounded_updown_counter;

    logic        clk = 1'b0;
    logic        clear, en, load, up_down;
    logic [3:0]  step;
    logic [1:0]  mode;
    logic [7:0]  d, lo, hi, qd;
    logic        tc, at_lo, at_hi, done;
    logic [15:0] d16, lo16, hi16, qd16;
    logic        tc16, at_lo16, at_hi16, done16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bounded_updown_counter #(.WIDTH(8), .STEP_W(4)) u8 (
        .clk(clk), .clear(clear), .en(en), .load(load), .d(d), .up_down(up_down),
        .step(step), .mode(mode), .lo(lo), .hi(hi), .qd(qd), .tc(tc),
        .at_lo(at_lo), .at_hi(at_hi), .done(done)
    );

    bounded_updown_counter #(.WIDTH(16), .STEP_W(4)) u16 (
        .clk(clk), .clear(clear), .en(en), .load(load), .d(d16), .up_down(up_down),
        .step(step), .mode(mode), .lo(lo16), .hi(hi16), .qd(qd16), .tc(tc16),
        .at_lo(at_lo16), .at_hi(at_hi16), .done(done16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] val);
        load = 1'b1; en = 1'b0; d = val;
        tick();
        load = 1'b0;
    endtask

    task automatic step_chk(input string tag, input logic [7:0] eq, input logic etc);
        tick();
        chk({tag, ".qd"}, qd, eq);
        chk({tag, ".tc"}, tc, etc);
    endtask

    initial begin
        clear = 1'b1; load = 1'b1; en = 1'b1; d = 8'h55; up_down = 1'b1;
        step = 4'd1; mode = 2'b00; lo = 8'd0; hi = 8'd255;
        d16 = 16'd0; lo16 = 16'd0; hi16 = 16'hFFFF;
        tick();
        chk("rst.qd", qd, 0);
        chk("rst.tc", tc, 0);
        chk("rst.done", done, 0);
        chk("rst.at_lo", at_lo, 1);
        chk("rst.at_hi", at_hi, 0);

        // load wins over en: no step taken on the load edge
        clear = 1'b0; load = 1'b1; en = 1'b1; d = 8'h55;
        tick();
        chk("load.qd", qd, 8'h55);
        load = 1'b0; en = 1'b0;

        // saturate up
        mode = 2'b00; lo = 8'd10; hi = 8'd20; step = 4'd3; up_down = 1'b1;
        do_load(8'd14);
        chk("sat.ld", qd, 14);
        en = 1'b1;
        step_chk("sat1", 8'd17, 1'b0);
        step_chk("sat2", 8'd20, 1'b0);
        chk("sat2.at_hi", at_hi, 1);
        step_chk("sat3", 8'd20, 1'b1);
        step_chk("sat4", 8'd20, 1'b1);
        en = 1'b0;
        step_chk("sat_idle", 8'd20, 1'b0);

        // wrap down
        mode = 2'b01; step = 4'd4; up_down = 1'b0;
        do_load(8'd13);
        en = 1'b1;
        step_chk("wrap1", 8'd20, 1'b1);
        step_chk("wrap2", 8'd16, 1'b0);
        step_chk("wrap3", 8'd12, 1'b0);
        step_chk("wrap4", 8'd20, 1'b1);

        // reload up
        mode = 2'b10; lo = 8'd0; hi = 8'd7; step = 4'd2; up_down = 1'b1;
        do_load(8'd5);
        en = 1'b1;
        step_chk("rl1", 8'd7, 1'b0);
        step_chk("rl2", 8'd5, 1'b1);
        step_chk("rl3", 8'd7, 1'b0);
        step_chk("rl4", 8'd5, 1'b1);

        // one-shot down with borrow guard
        mode = 2'b11; lo = 8'd0; hi = 8'd255; step = 4'd5; up_down = 1'b0;
        do_load(8'd3);
        en = 1'b1;
        step_chk("os1", 8'd0, 1'b1);
        chk("os1.done", done, 1);
        for (int i = 0; i < 3; i++) begin
            step_chk("os_stop", 8'd0, 1'b0);
            chk("os_stop.done", done, 1);
        end
        do_load(8'd9);
        chk("os_ld.qd", qd, 9);
        chk("os_ld.done", done, 0);
        en = 1'b1;
        step_chk("os_resume", 8'd4, 1'b0);

        // clear while stopped, with simultaneous load and en
        step_chk("os2", 8'd0, 1'b1);
        clear = 1'b1; load = 1'b1; d = 8'd77;
        tick();
        chk("clr_stop.qd", qd, 0);
        chk("clr_stop.tc", tc, 0);
        chk("clr_stop.done", done, 0);
        clear = 1'b0; load = 1'b0;

        // step = 0 holds
        mode = 2'b00; lo = 8'd0; hi = 8'd255; up_down = 1'b1;
        do_load(8'd100);
        step = 4'd0; en = 1'b1;
        for (int i = 0; i < 10; i++) step_chk("step0", 8'd100, 1'b0);

        // lo > hi ignores en
        lo = 8'd30; hi = 8'd20; step = 4'd3;
        step_chk("badwin1", 8'd100, 1'b0);
        step_chk("badwin2", 8'd100, 1'b0);

        // out-of-window above hi counting up is an event
        lo = 8'd10; hi = 8'd20; step = 4'd1;
        do_load(8'd200);
        en = 1'b1;
        step_chk("oow", 8'd20, 1'b1);

        // 16-bit saturate at top of range
        mode = 2'b00; up_down = 1'b1; lo16 = 16'd0; hi16 = 16'hFFFF;
        load = 1'b1; en = 1'b0; d16 = 16'd65534;
        tick();
        load = 1'b0;
        chk("w16.ld", qd16, 65534);
        step = 4'd15; en = 1'b1;
        tick();
        chk("w16.qd", qd16, 65535);
        chk("w16.tc", tc16, 1);
        en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
